// File: rtl/xm_mem_pkg.sv
// Shared types and defaults for the X-Makina memory port arbiter and its helpers.
package xm_mem_pkg;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F_RD = 3'd1,
    ST_D_RD = 3'd2,
    ST_D_WR = 3'd3,
    ST_RESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus watchdog: counts access cycles since the last clear and flags the final
// permitted cycle so the owner can abort instead of waiting forever.
module mem_timeout_counter
  import xm_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_CYCLE = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Saturates on the last cycle so a stalled owner cannot wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST_CYCLE)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST_CYCLE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (read-only) and data
// access (read/write); one transaction at a time, alternating under contention.
module mem_port_arbiter
  import xm_mem_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_req,
  input  logic [WORD-1:0] f_addr,
  output logic            f_done,
  output logic            f_err,
  output logic [WORD-1:0] f_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_done,
  output logic            d_err,
  output logic [WORD-1:0] d_rdata,
  output logic            MEM_rd_en,
  output logic            MEM_wr_en,
  output logic [WORD-1:0] MEM_rd_addr,
  output logic [WORD-1:0] MEM_wr_addr,
  output logic [WORD-1:0] MEM_wr_data,
  input  logic            MEM_rd_done,
  input  logic            MEM_wr_done,
  input  logic            MEM_rd_err,
  input  logic            MEM_wr_err,
  input  logic [WORD-1:0] MEM_data,
  output logic            grant_fetch
);

  arb_state_t      state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_owner_q, last_owner_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] f_data_q, f_data_d;
  logic [WORD-1:0] d_rdata_q, d_rdata_d;
  logic            err_q, err_d;

  logic grant;
  logic pick_data;
  logic in_access;
  logic to_expired;

  assign in_access = (state_q == ST_F_RD) || (state_q == ST_D_RD) || (state_q == ST_D_WR);

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .enable (in_access),
    .expired(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f_data_d     = f_data_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    grant        = 1'b0;
    pick_data    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          grant = 1'b1;
          // Under contention the requester that did not own the last transaction wins.
          pick_data = d_req && (!f_req || (last_owner_q == OWNER_FETCH));
          owner_d   = pick_data ? OWNER_DATA : OWNER_FETCH;
          addr_d    = pick_data ? d_addr : f_addr;
          err_d     = 1'b0;
          if (pick_data && d_we) begin
            wdata_d = d_wdata;
            state_d = ST_D_WR;
          end else begin
            state_d = pick_data ? ST_D_RD : ST_F_RD;
          end
        end
      end
      ST_F_RD, ST_D_RD: begin
        if (MEM_rd_done) begin
          err_d = MEM_rd_err;
          if (state_q == ST_D_RD) begin
            d_rdata_d = MEM_data;
          end else begin
            f_data_d = MEM_data;
          end
          state_d = ST_RESP;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_D_WR: begin
        if (MEM_wr_done) begin
          err_d   = MEM_wr_err;
          state_d = ST_RESP;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_FETCH;
      last_owner_q <= OWNER_DATA;
      addr_q       <= '0;
      wdata_q      <= '0;
      f_data_q     <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f_data_q     <= f_data_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign MEM_rd_en   = (state_q == ST_F_RD) || (state_q == ST_D_RD);
  assign MEM_wr_en   = (state_q == ST_D_WR);
  assign MEM_rd_addr = addr_q;
  assign MEM_wr_addr = addr_q;
  assign MEM_wr_data = wdata_q;
  assign grant_fetch = (state_q == ST_F_RD);

  assign f_done  = (state_q == ST_RESP) && (owner_q == OWNER_FETCH);
  assign d_done  = (state_q == ST_RESP) && (owner_q == OWNER_DATA);
  assign f_err   = f_done && err_q;
  assign d_err   = d_done && err_q;
  assign f_data  = f_data_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is compared
// against the DUT every cycle, plus literal expectations per scenario.
module tb_mem_port_arbiter;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         f_req, d_req, d_we;
  logic [W-1:0] f_addr, d_addr, d_wdata;
  logic         f_done, f_err, d_done, d_err;
  logic [W-1:0] f_data, d_rdata;
  logic         MEM_rd_en, MEM_wr_en;
  logic [W-1:0] MEM_rd_addr, MEM_wr_addr, MEM_wr_data;
  logic         MEM_rd_done, MEM_wr_done, MEM_rd_err, MEM_wr_err;
  logic [W-1:0] MEM_data;
  logic         grant_fetch;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD(W), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
    .MEM_rd_addr(MEM_rd_addr), .MEM_wr_addr(MEM_wr_addr), .MEM_wr_data(MEM_wr_data),
    .MEM_rd_done(MEM_rd_done), .MEM_wr_done(MEM_wr_done),
    .MEM_rd_err(MEM_rd_err), .MEM_wr_err(MEM_wr_err), .MEM_data(MEM_data),
    .grant_fetch(grant_fetch)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for a request, 1 memory access in flight, 2 response cycle
  int         m_phase;
  bit         m_owner;   // 0 fetch, 1 data
  bit         m_wr, m_err, m_last;
  int         m_age;
  logic [W-1:0] m_addr, m_wdata, m_fdata, m_drdata;

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_wr = 0; m_err = 0; m_last = 1; m_age = 0;
    m_addr = '0; m_wdata = '0; m_fdata = '0; m_drdata = '0;
  endtask

  task automatic m_step();
    bit done_in;
    case (m_phase)
      0: if (f_req || d_req) begin
        m_owner = (f_req && d_req) ? !m_last : !f_req;
        m_wr    = m_owner && d_we;
        m_addr  = m_owner ? d_addr : f_addr;
        if (m_wr) m_wdata = d_wdata;
        m_age   = 0;
        m_err   = 0;
        m_phase = 1;
      end
      1: begin
        done_in = m_wr ? MEM_wr_done : MEM_rd_done;
        if (done_in) begin
          m_err = m_wr ? MEM_wr_err : MEM_rd_err;
          if (!m_wr) begin
            if (m_owner) m_drdata = MEM_data; else m_fdata = MEM_data;
          end
          m_phase = 2;
        end else if (m_age + 1 >= TO) begin
          m_err   = 1;
          m_phase = 2;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_last  = m_owner;
        m_phase = 0;
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset(); else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_en",       32'(MEM_rd_en),   32'(m_phase == 1 && !m_wr));
      chk("wr_en",       32'(MEM_wr_en),   32'(m_phase == 1 && m_wr));
      chk("rd_addr",     32'(MEM_rd_addr), 32'(m_addr));
      chk("wr_addr",     32'(MEM_wr_addr), 32'(m_addr));
      chk("wr_data",     32'(MEM_wr_data), 32'(m_wdata));
      chk("grant_fetch", 32'(grant_fetch), 32'(m_phase == 1 && !m_owner));
      chk("f_done",      32'(f_done),      32'(m_phase == 2 && !m_owner));
      chk("f_err",       32'(f_err),       32'(m_phase == 2 && !m_owner && m_err));
      chk("d_done",      32'(d_done),      32'(m_phase == 2 && m_owner));
      chk("d_err",       32'(d_err),       32'(m_phase == 2 && m_owner && m_err));
      chk("f_data",      32'(f_data),      32'(m_fdata));
      chk("d_rdata",     32'(d_rdata),     32'(m_drdata));
    end
  end

  // ---------------- requesters and memory responder ----------------
  int f_issue = 0, d_issue = 0, f_served = 0, d_served = 0;
  int lat = 2;
  bit silent = 0, mem_err = 0;
  logic [W-1:0] mem_rdata = '0;
  int acc_rd = 0, acc_wr = 0, rd_en_cycles = 0, wr_en_cycles = 0;
  int rd_run = 0, last_rd_run = 0;
  logic [W-1:0] seen_rd_addr = '0, seen_wr_addr = '0, seen_wr_data = '0;
  bit last_f_err = 0, last_d_err = 0;
  int order[$];

  initial begin
    f_req = 0; d_req = 0;
    MEM_rd_done = 0; MEM_wr_done = 0; MEM_rd_err = 0; MEM_wr_err = 0; MEM_data = '0;
    forever begin
      @(negedge clk);
      if (f_done) begin
        f_served++; last_f_err = f_err; order.push_back(0);
        $display("txn FETCH err=%0b data=%h t=%0t", f_err, f_data, $time);
      end
      if (d_done) begin
        d_served++; last_d_err = d_err; order.push_back(1);
        $display("txn DATA  err=%0b rdata=%h t=%0t", d_err, d_rdata, $time);
      end
      f_req = (f_served < f_issue);
      d_req = (d_served < d_issue);
      if (MEM_rd_en) begin
        acc_rd++; rd_en_cycles++; rd_run++; seen_rd_addr = MEM_rd_addr;
      end else begin
        acc_rd = 0;
        if (rd_run > 0) begin last_rd_run = rd_run; rd_run = 0; end
      end
      if (MEM_wr_en) begin
        acc_wr++; wr_en_cycles++; seen_wr_addr = MEM_wr_addr; seen_wr_data = MEM_wr_data;
      end else begin
        acc_wr = 0;
      end
      MEM_rd_done = MEM_rd_en && !silent && (acc_rd == lat);
      MEM_rd_err  = MEM_rd_done && mem_err;
      MEM_data    = MEM_rd_done ? mem_rdata : 16'hDEAD;
      MEM_wr_done = MEM_wr_en && !silent && (acc_wr == lat);
      MEM_wr_err  = MEM_wr_done && mem_err;
    end
  end

  task automatic wait_all(input string nm);
    int n = 0;
    while ((f_served < f_issue || d_served < d_issue) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_completes"}, 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0, r0, w0, q0, n;
    reset = 1; f_addr = '0; d_addr = '0; d_wdata = '0; d_we = 0;
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 32'(MEM_rd_en), 32'd0);
    chk("reset_f_data", 32'(f_data), 32'd0);
    reset = 0;

    // fetch only, done two cycles into the access
    @(negedge clk);
    f_addr = 16'h0100; mem_rdata = 16'hBEEF; lat = 2; c0 = f_served;
    f_issue++;
    wait_all("fetch");
    chk("s1_rd_addr", 32'(seen_rd_addr), 32'h0100);
    chk("s1_f_data",  32'(f_data),       32'hBEEF);
    chk("s1_f_err",   32'(last_f_err),   32'd0);
    chk("s1_done_cnt", 32'(f_served - c0), 32'd1);

    // data write
    r0 = rd_en_cycles; w0 = wr_en_cycles;
    d_we = 1; d_addr = 16'h2000; d_wdata = 16'h1234; lat = 3;
    d_issue++;
    wait_all("write");
    chk("s2_wr_addr",  32'(seen_wr_addr), 32'h2000);
    chk("s2_wr_data",  32'(seen_wr_data), 32'h1234);
    chk("s2_no_rd_en", 32'(rd_en_cycles - r0), 32'd0);
    chk("s2_wr_len",   32'(wr_en_cycles - w0), 32'd3);
    chk("s2_d_err",    32'(last_d_err), 32'd0);

    // contention held from reset: strict alternation starting with fetch
    reset = 1; d_we = 0; lat = 1; mem_rdata = 16'h0A0A;
    f_addr = 16'h0200; d_addr = 16'h3000;
    q0 = order.size();
    f_issue += 2; d_issue += 2;
    repeat (2) @(negedge clk);
    reset = 0;
    wait_all("contention");
    chk("s3_count", 32'(order.size() - q0), 32'd4);
    if (order.size() >= q0 + 4) begin
      chk("s3_order0", 32'(order[q0]),   32'd0);
      chk("s3_order1", 32'(order[q0+1]), 32'd1);
      chk("s3_order2", 32'(order[q0+2]), 32'd0);
      chk("s3_order3", 32'(order[q0+3]), 32'd1);
    end

    // read error on a data access, then a clean fetch
    mem_err = 1; mem_rdata = 16'h7777;
    d_issue++;
    wait_all("rd_err");
    chk("s4_d_err",   32'(last_d_err), 32'd1);
    chk("s4_d_rdata", 32'(d_rdata),    32'h7777);
    mem_err = 0; mem_rdata = 16'h5A5A;
    f_issue++;
    wait_all("after_err");
    chk("s4_f_err",  32'(last_f_err), 32'd0);
    chk("s4_f_data", 32'(f_data),     32'h5A5A);

    // silent memory: fetch times out after TO access cycles
    silent = 1; f_addr = 16'h0400;
    f_issue++;
    wait_all("timeout");
    chk("s5_rd_run", 32'(last_rd_run), 32'd8);
    chk("s5_f_err",  32'(last_f_err),  32'd1);
    chk("s5_f_data", 32'(f_data),      32'h5A5A);

    // reset in the middle of a write, then contention resolves to fetch first
    d_we = 1; d_addr = 16'h4000; d_wdata = 16'h9999;
    d_issue++;
    n = 0;
    while (!MEM_wr_en && n < 20) begin @(negedge clk); n++; end
    chk("s6_wr_started", 32'(MEM_wr_en), 32'd1);
    @(posedge clk);
    #2 reset = 1;
    #1 chk("s6_wr_en_async", 32'(MEM_wr_en), 32'd0);
    @(negedge clk);
    silent = 0; lat = 1; d_we = 0; f_addr = 16'h0500; mem_rdata = 16'h0C0C;
    q0 = order.size();
    f_issue++;
    @(negedge clk);
    #1 reset = 0;
    wait_all("post_reset");
    chk("s6_count", 32'(order.size() - q0), 32'd2);
    if (order.size() >= q0 + 2) begin
      chk("s6_first_fetch", 32'(order[q0]),   32'd0);
      chk("s6_then_data",   32'(order[q0+1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single X-Makina memory port between the instruction-fetch requester (read-only) and the data-access requester (read/write). It sequences one memory transaction at a time and latches the address and write data at grant. It returns done/err pulses and read data to the owning requester, and applies a bus-timeout watchdog. It sits between the fetch/execute units and the memory model/controller.

Parameters:
WORD, 16, data and address width
TIMEOUT, 64, maximum cycles to wait for MEM_*_done before aborting the transaction with an error
TO_W, 7, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
f_req  input  1  fetch read request; level, held until f_done
f_addr  input  WORD  fetch address
f_done  output  1  one-cycle pulse: fetch complete (success or error)
f_err  output  1  valid with f_done: memory error or timeout
f_data  output  WORD  fetched word; held stable until the next fetch f_done
d_req  input  1  data request; level, held until d_done
d_we  input  1  1 = write, 0 = read; sampled at grant
d_addr  input  WORD  data address
d_wdata  input  WORD  write data
d_done  output  1  one-cycle pulse: data access complete
d_err  output  1  valid with d_done
d_rdata  output  WORD  read data; held until the next data read d_done
MEM_rd_en  output  1  memory read strobe; level, held for the whole transaction
MEM_wr_en  output  1  memory write strobe; level, held for the whole transaction
MEM_rd_addr  output  WORD  read address
MEM_wr_addr  output  WORD  write address
MEM_wr_data  output  WORD  write data
MEM_rd_done  input  1  read complete
MEM_wr_done  input  1  write complete
MEM_rd_err  input  1  read error, valid with MEM_rd_done
MEM_wr_err  input  1  write error, valid with MEM_wr_done
MEM_data  input  WORD  read data, valid with MEM_rd_done
grant_fetch  output  1  status: fetch owns the port (states F_RD)

Behaviour:
- Reset (asynchronous): state IDLE. All enables, done and err outputs 0; addresses, data, f_data and d_rdata 0; timeout counter 0; last_owner = DATA, so fetch wins the first tie.
- States: IDLE, F_RD, D_RD, D_WR, RESP.
- IDLE, grant evaluation each cycle:
  - only f_req set -> F_RD.
  - only d_req set -> D_RD if d_we = 0, D_WR if d_we = 1.
  - both set -> grant the requester that is not last_owner (strict alternation under contention).
  - Grant registers the address and write data and asserts the enable on the next edge. IDLE to enable is 1 cycle.
- F_RD / D_RD:
  - MEM_rd_en = 1, MEM_rd_addr = latched address.
  - On MEM_rd_done, capture MEM_data into f_data or d_rdata and capture the error as MEM_rd_err; go to RESP.
- D_WR:
  - MEM_wr_en = 1 with the latched address and data.
  - On MEM_wr_done, capture the error as MEM_wr_err; go to RESP.
  - The read/write data register is not modified.
- Timeout:
  - The counter clears at grant and increments each cycle while in F_RD, D_RD or D_WR without the matching done.
  - When it reaches TIMEOUT-1 without done: deassert the enable, set error = 1, go to RESP; the data register is unchanged.
  - Done and timeout in the same cycle: done wins.
- RESP: lasts one cycle.
  - Enables are 0.
  - The owner's done pulses 1 with its err; update last_owner.
  - Next state is IDLE.
  - Minimum transaction with a 1-cycle done: grant cycle, access cycle, RESP cycle.
- Only the matching done/err is honoured: MEM_wr_done during a read and any done in IDLE or RESP are ignored.
- A requester dropping its req mid-transaction does not abort it; the done pulse is still issued.
- A requester may re-raise its req the cycle after its done. It may also hold req continuously; each held cycle in IDLE counts as a new request.
- MEM_rd_en and MEM_wr_en are never both 1.

Decomposition:
- Shared package xm_mem_pkg:
  - typedef enum for arbiter states.
  - typedef owner_t {OWNER_FETCH, OWNER_DATA}.
  - Constant TIMEOUT_DEFAULT.
- One natural sub-module: mem_timeout_counter (clear, enable, expired output), reused by memory_interfacer revisions.

Test Plan:
- Fetch only: f_req = 1, f_addr = 16'h0100; memory returns done 2 cycles after MEM_rd_en with MEM_data = 16'hBEEF -> MEM_rd_addr = 16'h0100, f_done pulses once, f_err = 0, f_data = 16'hBEEF.
- Data write: d_req = 1, d_we = 1, d_addr = 16'h2000, d_wdata = 16'h1234 -> MEM_wr_en with matching address and data until MEM_wr_done; d_done pulses; MEM_rd_en stays 0 throughout.
- Contention: f_req and d_req held high from reset for 4 transactions -> grant order FETCH, DATA, FETCH, DATA.
- Error path: MEM_rd_err = 1 with MEM_rd_done on a data read -> d_done = 1 with d_err = 1; the next transaction starts normally.
- Timeout: TIMEOUT = 8 and memory never responds to a fetch -> MEM_rd_en drops after 8 cycles, then f_done and f_err pulse; f_data keeps its previous value.
- Reset mid-transaction: assert reset during D_WR -> MEM_wr_en = 0 immediately (asynchronously); after release, f_req alone is granted first.
